// File: rtl/word_game_core.sv
// Hangman-style guessing core: a secret word is loaded, guesses are scanned one
// letter per cycle, then scored as hit, miss or repeat against revealed state and a miss buffer.
module word_game_core #(
  parameter int WORD_LEN = 5,
  parameter int MAX_MISS = 6,
  parameter int LW       = 8,
  localparam int CW      = $clog2(WORD_LEN + 1),
  localparam int MW      = $clog2(MAX_MISS + 1),
  localparam int IW      = $clog2(WORD_LEN)
) (
  input  logic                   clk,
  input  logic                   nRst,
  input  logic                   word_valid,
  input  logic [WORD_LEN*LW-1:0] word,
  input  logic                   guess_valid,
  input  logic [LW-1:0]          guess,
  input  logic                   game_end,
  output logic                   guess_ready,
  output logic                   busy,
  output logic                   hit,
  output logic                   miss,
  output logic                   repeat_guess,
  output logic [WORD_LEN-1:0]    revealed,
  output logic [CW-1:0]          correct_cnt,
  output logic [MW-1:0]          miss_cnt,
  output logic                   win,
  output logic                   lose,
  output logic [LW-1:0]          last_letter
);

  typedef enum logic [2:0] {S_SET, S_READY, S_SCAN, S_SCORE, S_WIN, S_LOSE} state_t;

  state_t              state_q;
  logic [LW-1:0]       letters_q  [WORD_LEN];
  logic [LW-1:0]       miss_buf_q [MAX_MISS];
  logic [WORD_LEN-1:0] revealed_q;
  logic [WORD_LEN-1:0] pending_q;
  logic                dup_q;
  logic [IW-1:0]       idx_q;
  logic [CW-1:0]       correct_cnt_q;
  logic [MW-1:0]       miss_cnt_q;
  logic [LW-1:0]       last_letter_q;

  logic [CW-1:0] pop;
  logic [CW:0]   sum;
  logic [CW-1:0] correct_d;
  logic [MW-1:0] miss_d;
  logic          in_buf;
  logic          score_hit;
  logic          score_rep;
  logic          score_miss;
  state_t        after_score;

  // Score outcome depends only on registered scan results, so the pulses are clean.
  always_comb begin
    pop = '0;
    for (int i = 0; i < WORD_LEN; i++) pop = pop + CW'(pending_q[i]);
    in_buf = 1'b0;
    for (int j = 0; j < MAX_MISS; j++) if (miss_buf_q[j] == last_letter_q) in_buf = 1'b1;
    sum        = {1'b0, correct_cnt_q} + {1'b0, pop};
    correct_d  = (sum > (CW+1)'(WORD_LEN)) ? CW'(WORD_LEN) : sum[CW-1:0];
    miss_d     = (miss_cnt_q == MW'(MAX_MISS)) ? miss_cnt_q : miss_cnt_q + 1'b1;
    score_hit  = |pending_q;
    score_rep  = !score_hit && (dup_q || in_buf);
    score_miss = !score_hit && !score_rep;
    if ((score_hit ? correct_d : correct_cnt_q) == CW'(WORD_LEN))
      after_score = S_WIN;
    else if ((score_miss ? miss_d : miss_cnt_q) == MW'(MAX_MISS))
      after_score = S_LOSE;
    else
      after_score = S_READY;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q       <= S_SET;
      for (int i = 0; i < WORD_LEN; i++) letters_q[i] <= '0;
      for (int j = 0; j < MAX_MISS; j++) miss_buf_q[j] <= '0;
      revealed_q    <= '0;
      pending_q     <= '0;
      dup_q         <= 1'b0;
      idx_q         <= '0;
      correct_cnt_q <= '0;
      miss_cnt_q    <= '0;
      last_letter_q <= '0;
    end else if (game_end) begin
      state_q       <= S_SET;
      for (int i = 0; i < WORD_LEN; i++) letters_q[i] <= '0;
      for (int j = 0; j < MAX_MISS; j++) miss_buf_q[j] <= '0;
      revealed_q    <= '0;
      pending_q     <= '0;
      dup_q         <= 1'b0;
      idx_q         <= '0;
      correct_cnt_q <= '0;
      miss_cnt_q    <= '0;
      last_letter_q <= '0;
    end else begin
      case (state_q)
        S_SET: if (word_valid) begin
          for (int i = 0; i < WORD_LEN; i++) letters_q[i] <= word[(WORD_LEN-1-i)*LW +: LW];
          for (int j = 0; j < MAX_MISS; j++) miss_buf_q[j] <= '0;
          revealed_q    <= '0;
          correct_cnt_q <= '0;
          miss_cnt_q    <= '0;
          state_q       <= S_READY;
        end
        S_READY: if (guess_valid && guess != '0) begin
          last_letter_q <= guess;
          pending_q     <= '0;
          dup_q         <= 1'b0;
          idx_q         <= '0;
          state_q       <= S_SCAN;
        end
        S_SCAN: begin
          if (letters_q[idx_q] == last_letter_q) begin
            if (revealed_q[idx_q]) dup_q <= 1'b1;
            else                   pending_q[idx_q] <= 1'b1;
          end
          if (idx_q == IW'(WORD_LEN - 1)) state_q <= S_SCORE;
          else                            idx_q   <= idx_q + 1'b1;
        end
        S_SCORE: begin
          if (score_hit) begin
            revealed_q    <= revealed_q | pending_q;
            correct_cnt_q <= correct_d;
          end else if (score_miss) begin
            miss_cnt_q <= miss_d;
            // Buffer slot is the current miss count, so entries fill in order.
            for (int j = 0; j < MAX_MISS; j++)
              if (miss_cnt_q == MW'(j)) miss_buf_q[j] <= last_letter_q;
          end
          state_q <= after_score;
        end
        default: ;
      endcase
    end
  end

  assign guess_ready  = (state_q == S_READY);
  assign busy         = (state_q == S_SCAN) || (state_q == S_SCORE);
  assign hit          = (state_q == S_SCORE) && score_hit;
  assign miss         = (state_q == S_SCORE) && score_miss;
  assign repeat_guess = (state_q == S_SCORE) && score_rep;
  assign win          = (state_q == S_WIN);
  assign lose         = (state_q == S_LOSE);
  assign revealed     = revealed_q;
  assign correct_cnt  = correct_cnt_q;
  assign miss_cnt     = miss_cnt_q;
  assign last_letter  = last_letter_q;

endmodule

// File: tb/tb_word_game_core.sv
// Scoreboard bench for word_game_core: the stimulus queues expected results,
// a monitor pops one per result pulse and checks kind, timing and post-score state.
module tb_word_game_core;
  localparam int WL = 5;
  localparam int K_HIT = 0, K_MISS = 1, K_REP = 2;

  logic          clk = 1'b0;
  logic          nRst = 1'b0;
  logic          word_valid = 1'b0;
  logic [39:0]   word = '0;
  logic          guess_valid = 1'b0;
  logic [7:0]    guess = '0;
  logic          game_end = 1'b0;
  logic          guess_ready, busy, hit, miss, repeat_guess, win, lose;
  logic [WL-1:0] revealed;
  logic [2:0]    correct_cnt;
  logic [2:0]    miss_cnt;
  logic [7:0]    last_letter;

  word_game_core dut (
    .clk(clk), .nRst(nRst), .word_valid(word_valid), .word(word),
    .guess_valid(guess_valid), .guess(guess), .game_end(game_end),
    .guess_ready(guess_ready), .busy(busy), .hit(hit), .miss(miss),
    .repeat_guess(repeat_guess), .revealed(revealed), .correct_cnt(correct_cnt),
    .miss_cnt(miss_cnt), .win(win), .lose(lose), .last_letter(last_letter)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            kind;
    logic [WL-1:0] rev;
    int            corr;
    int            mis;
    bit            w;
    bit            l;
    int            at;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every result pulse must match the head of the scoreboard.
  initial begin
    exp_t e;
    int   kind;
    forever begin
      @(negedge clk);
      if (nRst && (hit || miss || repeat_guess)) begin
        kind = hit ? K_HIT : (miss ? K_MISS : K_REP);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {29'd0, hit, miss, repeat_guess}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_onehot", 32'(hit) + 32'(miss) + 32'(repeat_guess), 32'd1);
          check("pulse_kind", kind, e.kind);
          check("pulse_cycle", cyc, e.at);
          check("busy_in_score", busy, 1'b1);
          @(negedge clk);
          check("revealed", revealed, e.rev);
          check("correct_cnt", correct_cnt, e.corr);
          check("miss_cnt", miss_cnt, e.mis);
          check("win", win, e.w);
          check("lose", lose, e.l);
          check("ready_after_score", guess_ready, !(e.w || e.l));
          $display("result kind=%0d rev=%b corr=%0d miss=%0d win=%0d lose=%0d",
                   kind, revealed, correct_cnt, miss_cnt, win, lose);
          done_cnt++;
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!guess_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!guess_ready) check("ready_timeout", guess_ready, 1'b1);
  endtask

  task automatic load_word(input logic [39:0] w);
    word_valid = 1'b1;
    word       = w;
    @(negedge clk);
    word_valid = 1'b0;
    check("ready_after_load", guess_ready, 1'b1);
  endtask

  task automatic do_guess(input logic [7:0] g, input int kind, input logic [WL-1:0] rev,
                          input int corr, input int mis, input bit w, input bit l);
    exp_t e;
    int   target;
    int   n = 0;
    wait_ready();
    target = done_cnt + 1;
    e = '{kind: kind, rev: rev, corr: corr, mis: mis, w: w, l: l, at: cyc + WL + 1};
    exp_q.push_back(e);
    guess_valid = 1'b1;
    guess       = g;
    @(negedge clk);
    guess_valid = 1'b0;
    guess       = '0;
    check("last_letter", last_letter, g);
    while (done_cnt < target && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt < target) begin
      check("result_timeout", done_cnt, target);
      exp_q.delete();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {guess_ready, busy, hit, miss, repeat_guess, win, lose}, 7'd0);
    check({tag, "_revealed"}, revealed, '0);
    check({tag, "_counts"}, {correct_cnt, miss_cnt}, 6'd0);
    check({tag, "_last_letter"}, last_letter, 8'd0);
  endtask

  task automatic try_ignored(input logic [7:0] g);
    guess_valid = 1'b1;
    guess       = g;
    repeat (3) @(negedge clk);
    guess_valid = 1'b0;
    guess       = '0;
    repeat (WL + 3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset_held");
    nRst = 1'b1;
    @(negedge clk);
    check_all_zero("reset_released");

    // Bit i is letter i, so "APPLE" with P revealed is 5'b00110 (01100 in letter order).
    load_word("APPLE");
    do_guess("P", K_HIT,  5'b00110, 2, 0, 0, 0);
    do_guess("P", K_REP,  5'b00110, 2, 0, 0, 0);
    do_guess("Z", K_MISS, 5'b00110, 2, 1, 0, 0);
    do_guess("Z", K_REP,  5'b00110, 2, 1, 0, 0);
    do_guess("A", K_HIT,  5'b00111, 3, 1, 0, 0);
    do_guess("L", K_HIT,  5'b01111, 4, 1, 0, 0);
    do_guess("E", K_HIT,  5'b11111, 5, 1, 1, 0);
    try_ignored("Q");
    check("win_hold", {win, lose, busy}, 3'b100);
    check("win_last_letter", last_letter, "E");

    game_end = 1'b1;
    @(negedge clk);
    game_end = 1'b0;
    check_all_zero("after_win_end");

    load_word("APPLE");
    do_guess("B", K_MISS, 5'b00000, 0, 1, 0, 0);
    do_guess("C", K_MISS, 5'b00000, 0, 2, 0, 0);
    do_guess("D", K_MISS, 5'b00000, 0, 3, 0, 0);
    do_guess("F", K_MISS, 5'b00000, 0, 4, 0, 0);
    do_guess("G", K_MISS, 5'b00000, 0, 5, 0, 0);
    do_guess("H", K_MISS, 5'b00000, 0, 6, 0, 1);
    try_ignored("A");
    check("lose_hold", {win, lose, busy, guess_ready}, 4'b0100);
    check("lose_miss_cnt", miss_cnt, 3'd6);

    game_end = 1'b1;
    @(negedge clk);
    game_end = 1'b0;
    load_word("APPLE");
    do_guess("A", K_HIT, 5'b00001, 1, 0, 0, 0);
    // Abort a scan two cycles in; no pulse may follow.
    wait_ready();
    guess_valid = 1'b1;
    guess       = "P";
    @(negedge clk);
    guess_valid = 1'b0;
    guess       = '0;
    @(negedge clk);
    check("busy_mid_scan", busy, 1'b1);
    game_end = 1'b1;
    @(negedge clk);
    game_end = 1'b0;
    check_all_zero("abort_scan");
    repeat (WL + 3) @(negedge clk);
    check("abort_stays_set", guess_ready, 1'b0);

    load_word("APPLE");
    do_guess("A", K_HIT, 5'b00001, 1, 0, 0, 0);
    do_guess("P", K_HIT, 5'b00111, 3, 0, 0, 0);
    check("ready_before_reset", guess_ready, 1'b1);
    #2 nRst = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    nRst = 1'b1;
    @(negedge clk);
    load_word("APPLE");
    guess_valid = 1'b1;
    guess       = 8'd0;
    repeat (3) @(negedge clk);
    guess_valid = 1'b0;
    check("zero_guess_ignored", {guess_ready, busy}, 2'b10);
    check("zero_guess_last", last_letter, 8'd0);
    repeat (WL + 3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/word_game_core.md
WORD_GAME_CORE -- requirements
Module: word_game_core

Interface
REQ-001 SHALL provide parameter WORD_LEN, default 5, number of letters in the secret word (2..16).
REQ-002 SHALL provide parameter MAX_MISS, default 6, number of misses that loses the game (1..15).
REQ-003 SHALL provide parameter LW, default 8, letter width in bits.
REQ-004 clk  input  1  clock; reset nRst, asynchronous, active-low.
REQ-005 nRst  input  1  asynchronous active-low reset.
REQ-006 word_valid  input  1  load secret word (SET state only).
REQ-007 word  input  WORD_LEN*LW  secret word; letter 0 in the MSBs.
REQ-008 guess_valid  input  1  guess offered.
REQ-009 guess  input  LW  guessed letter; value 0 means no letter.
REQ-010 game_end  input  1  abort or restart request.
REQ-011 guess_ready  output  1  high only in READY.
REQ-012 busy  output  1  high in SCAN and SCORE.
REQ-013 hit, miss, repeat_guess  output  1 each  one-cycle result pulses.
REQ-014 revealed  output  WORD_LEN  bit i set once letter i has been guessed.
REQ-015 correct_cnt  output  clog2(WORD_LEN+1)  number of revealed positions.
REQ-016 miss_cnt  output  clog2(MAX_MISS+1)  number of misses.
REQ-017 win, lose  output  1 each  level outputs; high in WIN and LOSE respectively.
REQ-018 last_letter  output  LW  most recently accepted guess.

Function
REQ-019 SHALL implement states SET, READY, SCAN, SCORE, WIN and LOSE.
REQ-020 SET: when word_valid is high, word SHALL be captured; revealed, both counters and the miss buffer SHALL be cleared; next state is READY.
REQ-021 READY: when guess_valid is high and guess != 0, the guess SHALL be accepted, last_letter SHALL update, and next state is SCAN. guess_valid with guess = 0 SHALL be ignored.
REQ-022 SCAN SHALL last exactly WORD_LEN cycles.
  - Cycle k compares last_letter with letter k.
  - A match on an unrevealed position sets a pending-hit bit.
  - A match on an already revealed position sets a dup flag.
REQ-023 SCORE SHALL last one cycle and apply the first matching case below.
  - Pending hits present: OR them into revealed, add their popcount to correct_cnt, pulse hit.
  - Dup flag set, or last_letter already in the miss buffer: pulse repeat_guess; no counter change.
  - Otherwise: pulse miss, increment miss_cnt, write last_letter into the miss buffer.
REQ-024 Miss buffer SHALL have MAX_MISS entries of LW bits, filled in order, and SHALL be compared in parallel in SCORE.
REQ-025 After SCORE, next state SHALL be WIN if correct_cnt equals WORD_LEN, else LOSE if miss_cnt equals MAX_MISS, else READY; the decision uses the post-update values.
REQ-026 Accept-to-result latency SHALL be WORD_LEN+1 cycles; guess_ready SHALL return high on the cycle after SCORE.
REQ-027 Exactly one of hit, miss or repeat_guess SHALL pulse per accepted guess; none SHALL pulse outside SCORE.
REQ-028 WIN and LOSE SHALL hold until game_end; guesses there SHALL be ignored.
REQ-029 game_end SHALL have priority over every other input in every state: next state SET, and all outputs and storage cleared as at reset. A scan in progress SHALL be discarded.
REQ-030 Counters SHALL saturate and never wrap.
REQ-031 A guess matching several positions SHALL reveal all of them in one SCORE.

Reset
REQ-032 nRst low SHALL asynchronously force state SET and clear all outputs and storage: revealed = 0, both counters = 0, last_letter = 0, word = 0, miss buffer = 0, and all pulses and levels low.

Verification
REQ-033 Word "APPLE" loaded, guess 'P' -> after 6 cycles hit pulses, revealed = 01100, correct_cnt = 2.
REQ-034 'P' guessed again -> repeat_guess pulses, counts unchanged; then 'Z' twice -> miss once (miss_cnt = 1), then repeat_guess.
REQ-035 Six distinct wrong letters -> miss_cnt = 6, lose high, further guess_valid ignored.
REQ-036 Guesses A, P, L, E -> win high after the fourth SCORE, correct_cnt = 5.
REQ-037 game_end asserted mid-SCAN -> SET next cycle, no result pulse, all outputs 0.
REQ-038 nRst pulsed in READY with correct_cnt = 3 -> all outputs 0 immediately; guess = 0 with guess_valid high -> no acceptance.
